// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
//   arb_state_t  - arbiter FSM state
//   idx_width()  - bits needed to index N requesters (at least 1)
//   cnt_width()  - bits needed to hold a count of 0..max (at least 1)
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbActive = 2'd1,
        ArbGap    = 2'd2
    } arb_state_t;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  in   N_REQ  request vector
//   ptr  in   IW     highest-priority index for this pick
//   any  out  1      at least one request is set
//   idx  out  IW     first set request scanning ptr, ptr+1, ... mod N_REQ
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] ptr,
    output logic                        any,
    output logic [idx_width(N_REQ)-1:0] idx
);

    localparam int unsigned IW = idx_width(N_REQ);

    // Scan from the farthest offset down to zero so the nearest hit to ptr wins last.
    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= int'(N_REQ)) begin
                j = j - int'(N_REQ);
            end
            if (req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among N_REQ sources.
// A grant is held until the owner's last byte is accepted, followed by an idle gap;
// a watchdog aborts a grant that sees no handshake for STALL_CYCLES clocks.
//   clock      in   1        system clock
//   reset      in   1        synchronous active-high reset
//   req_valid  in   N_REQ    per-requester byte valid
//   req_data   in   N_REQ*8  per-requester byte, requester i on bits [8i+7:8i]
//   req_last   in   N_REQ    last byte of packet, qualified by req_valid
//   req_ready  out  N_REQ    byte accepted this cycle (one-hot or zero)
//   tx_valid   out  1        byte offered to transmitter
//   tx_data    out  8        byte to transmitter
//   tx_ready   in   1        transmitter accepting
//   grant_id   out  IW       current or last grant
//   busy       out  1        arbiter not idle
//   abort      out  1        one-cycle pulse when watchdog kills a grant
//   pkt_count  out  16       completed packets (wrapping)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned GAP_CYCLES   = 40000,
    parameter int unsigned STALL_CYCLES = 480000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*8-1:0]          req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        tx_valid,
    output logic [7:0]                  tx_data,
    input  logic                        tx_ready,
    output logic [idx_width(N_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic                        abort,
    output logic [15:0]                 pkt_count
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);
    localparam int unsigned SW = cnt_width(STALL_CYCLES);

    localparam logic [GW-1:0] GAP_LOAD    = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SW-1:0] STALL_LIMIT = SW'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
    localparam logic [SW-1:0] STALL_MAX   = SW'(STALL_CYCLES);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N_REQ - 1);
    // With no gap configured, packet end and abort go straight back to arbitration.
    localparam arb_state_t    POST_STATE  = (GAP_CYCLES == 0) ? ArbIdle : ArbGap;

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [GW-1:0] gap_cnt;
    logic [SW-1:0] stall_cnt;

    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          active;
    logic          g_valid;
    logic          g_last;
    logic          handshake;
    logic [IW-1:0] next_ptr;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Explicit wrap so non-power-of-two N_REQ never yields an unused index.
    assign next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    assign active    = (state == ArbActive);
    assign g_valid   = req_valid[grant_id];
    assign g_last    = req_last[grant_id];
    assign handshake = active && g_valid && tx_ready;

    assign tx_valid  = active && g_valid;
    assign tx_data   = active ? req_data[8*grant_id +: 8] : 8'h00;
    assign busy      = (state != ArbIdle);

    always_comb begin
        req_ready = '0;
        if (active) begin
            req_ready[grant_id] = tx_ready;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ArbIdle;
            rr_ptr    <= '0;
            grant_id  <= '0;
            pkt_count <= '0;
            gap_cnt   <= '0;
            stall_cnt <= '0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ArbIdle: begin
                    if (pick_any) begin
                        grant_id  <= pick_idx;
                        stall_cnt <= '0;
                        state     <= ArbActive;
                    end
                end
                ArbActive: begin
                    if (handshake) begin
                        stall_cnt <= '0;
                        if (g_last) begin
                            pkt_count <= pkt_count + 16'd1;
                            rr_ptr    <= next_ptr;
                            gap_cnt   <= GAP_LOAD;
                            state     <= POST_STATE;
                        end
                    end else if (STALL_CYCLES != 0 && stall_cnt == STALL_LIMIT) begin
                        abort   <= 1'b1;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= GAP_LOAD;
                        state   <= POST_STATE;
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                ArbGap: begin
                    if (gap_cnt == '0) begin
                        state <= ArbIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected (grant, byte) pairs,
// a negedge monitor pops and compares on every tx handshake.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;
    logic [15:0]    pkt_count;

    logic           b_reset;
    logic [N-1:0]   b_req_valid;
    logic [N*8-1:0] b_req_data;
    logic [N-1:0]   b_req_last;
    logic [N-1:0]   b_req_ready;
    logic           b_tx_valid;
    logic [7:0]     b_tx_data;
    logic           b_tx_ready;
    logic [1:0]     b_grant_id;
    logic           b_busy;
    logic           b_abort;
    logic [15:0]    b_pkt_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_c2     = 0;
    int t_d0     = 0;
    logic byte1_done = 1'b0;

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .GAP_CYCLES   (4),
        .STALL_CYCLES (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort),
        .pkt_count (pkt_count)
    );

    uart_tx_arbiter #(
        .N_REQ        (N),
        .GAP_CYCLES   (4),
        .STALL_CYCLES (0)
    ) dut_b (
        .clock     (clock),
        .reset     (b_reset),
        .req_valid (b_req_valid),
        .req_data  (b_req_data),
        .req_last  (b_req_last),
        .req_ready (b_req_ready),
        .tx_valid  (b_tx_valid),
        .tx_data   (b_tx_data),
        .tx_ready  (b_tx_ready),
        .grant_id  (b_grant_id),
        .busy      (b_busy),
        .abort     (b_abort),
        .pkt_count (b_pkt_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_byte(input int g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Offer one byte from requester r and return #1 after the edge that accepts it.
    task automatic send(input int r, input logic [7:0] d, input logic l);
        int t;
        t = 0;
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = d;
        req_last[r]        = l;
        while (1) begin
            @(negedge clock);
            if (req_ready[r]) break;
            t++;
            if (t > 100) begin
                timeout("send_wait");
                return;
            end
        end
        tick();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy) begin
            tick();
            t++;
            if (t > 100) begin
                timeout(name);
                break;
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: actual grant=%0d data=0x%0h required=no transfer",
                         grant_id, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_grant", 32'(grant_id), 32'(mon_e.g));
                check("sb_data", 32'(tx_data), 32'(mon_e.d));
                check("sb_req_ready", 32'(req_ready), 32'(1) << mon_e.g);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '1;
        req_data    = '0;
        req_last    = '0;
        tx_ready    = 1'b1;
        b_reset     = 1'b1;
        b_req_valid = '0;
        b_req_data  = '0;
        b_req_last  = '0;
        b_tx_ready  = 1'b0;

        // Reset held with every requester valid.
        repeat (3) begin
            tick();
            check("rst_tx_valid", 32'(tx_valid), 0);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_pkt_count", 32'(pkt_count), 0);
        end
        reset     = 1'b0;
        b_reset   = 1'b0;
        req_valid = '0;
        tick();
        check("post_rst_tx_valid", 32'(tx_valid), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_grant", 32'(grant_id), 0);
        check("post_rst_abort", 32'(abort), 0);

        // Single requester, two-byte packet, then exactly 4 gap cycles.
        expect_byte(1, 8'h48);
        expect_byte(1, 8'h69);
        send(1, 8'h48, 1'b0);
        send(1, 8'h69, 1'b1);
        req_valid[1] = 1'b0;
        check("single_pkt_count", 32'(pkt_count), 1);
        for (int k = 0; k < 4; k++) begin
            check("gap_busy", 32'(busy), 1);
            check("gap_tx_valid", 32'(tx_valid), 0);
            tick();
        end
        check("gap_end_idle", 32'(busy), 0);
        check("single_grant_held", 32'(grant_id), 1);

        // Round-robin: rr_ptr is 2, so grants go 2,0,2,0.
        expect_byte(2, 8'hA0);
        expect_byte(0, 8'hB0);
        expect_byte(2, 8'hA1);
        expect_byte(0, 8'hB1);
        fork
            begin
                send(2, 8'hA0, 1'b1);
                send(2, 8'hA1, 1'b1);
                req_valid[2] = 1'b0;
            end
            begin
                send(0, 8'hB0, 1'b1);
                send(0, 8'hB1, 1'b1);
                req_valid[0] = 1'b0;
            end
        join
        wait_idle("rr_idle");
        check("rr_pkt_count", 32'(pkt_count), 5);

        // No interleave: req3 arrives mid-packet and waits for gap + arbitration.
        expect_byte(0, 8'hC0);
        expect_byte(0, 8'hC1);
        expect_byte(0, 8'hC2);
        expect_byte(3, 8'hD0);
        fork
            begin
                send(0, 8'hC0, 1'b0);
                byte1_done = 1'b1;
                send(0, 8'hC1, 1'b0);
                send(0, 8'hC2, 1'b1);
                t_c2 = cyc;
                req_valid[0] = 1'b0;
            end
            begin
                wait (byte1_done);
                send(3, 8'hD0, 1'b1);
                t_d0 = cyc;
                req_valid[3] = 1'b0;
            end
        join
        check("noint_gap_latency", 32'(t_d0 - t_c2), 6);
        wait_idle("noint_idle");
        check("noint_pkt_count", 32'(pkt_count), 7);

        // Stall: one byte without last, then silence; abort 8 cycles after that handshake.
        expect_byte(2, 8'hE0);
        send(2, 8'hE0, 1'b0);
        req_valid[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("stall_no_early_abort", 32'(abort), 0);
            tick();
        end
        check("stall_abort", 32'(abort), 1);
        check("stall_pkt_count", 32'(pkt_count), 7);
        check("stall_gap_busy", 32'(busy), 1);
        tick();
        check("stall_abort_pulse", 32'(abort), 0);
        wait_idle("stall_idle");
        // rr_ptr=3 after the abort, so req3 beats req1.
        expect_byte(3, 8'hF0);
        expect_byte(1, 8'hF1);
        fork
            begin
                send(3, 8'hF0, 1'b1);
                req_valid[3] = 1'b0;
            end
            begin
                send(1, 8'hF1, 1'b1);
                req_valid[1] = 1'b0;
            end
        join
        wait_idle("post_stall_idle");
        check("post_stall_pkt_count", 32'(pkt_count), 9);

        // Backpressure with watchdog off, then reset mid-packet.
        b_req_valid[0]  = 1'b1;
        b_req_data[7:0] = 8'h5A;
        b_req_last[0]   = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_tx_valid", 32'(b_tx_valid), 1);
            check("bp_tx_data", 32'(b_tx_data), 32'h5A);
            check("bp_abort", 32'(b_abort), 0);
            check("bp_req_ready", 32'(b_req_ready), 0);
            tick();
        end
        b_tx_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(b_req_ready), 1);
        tick();
        b_req_data[7:0] = 8'h5B;
        b_tx_ready      = 1'b0;
        #1;
        check("bp_mid_busy", 32'(b_busy), 1);
        check("bp_mid_data", 32'(b_tx_data), 32'h5B);
        b_reset = 1'b1;
        tick();
        check("bp_rst_tx_valid", 32'(b_tx_valid), 0);
        check("bp_rst_busy", 32'(b_busy), 0);
        check("bp_rst_req_ready", 32'(b_req_ready), 0);
        check("bp_rst_pkt_count", 32'(b_pkt_count), 0);
        b_reset     = 1'b0;
        b_req_valid = '0;
        tick();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
